// File: rtl/transpose_buffer_pkg.sv
// transpose_buffer_pkg: shared coefficient width, block size and fill/drain state type
package transpose_buffer_pkg;
  localparam int COEF_W = 8;
  localparam int BLK_N = 8;
  typedef logic [COEF_W-1:0] coef_t;
  typedef enum logic {FILL, DRAIN} state_t;
endpackage

// File: rtl/transpose_buffer.sv
// transpose_buffer: collects an NxN block row by row, then replays it column by column
import transpose_buffer_pkg::*;
module transpose_buffer #(
  parameter int WIDTH = COEF_W,
  parameter int N = BLK_N,
  localparam int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_in,
  output logic             rdy_out,
  input  logic [WIDTH-1:0] in,
  input  logic             rdy_in,
  output logic             ena_out,
  output logic [WIDTH-1:0] out
);
  state_t state;
  logic [IW-1:0] r, c;
  logic [WIDTH-1:0] mem [N][N];
  logic we, last;
  always_comb begin
    rdy_out = state == FILL;
    ena_out = state == DRAIN && (rdy_in || r != '0);
    out = mem[r][c];
    we = rdy_out && ena_in && !rst;
    last = r == IW'(N - 1) && c == IW'(N - 1);
  end
  // N is a power of two, so the counters wrap to zero on their own at the block end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      r <= '0;
      c <= '0;
    end else if (we) begin
      c <= c + 1'b1;
      if (c == IW'(N - 1)) r <= r + 1'b1;
      if (last) state <= DRAIN;
    end else if (ena_out) begin
      r <= r + 1'b1;
      if (r == IW'(N - 1)) c <= c + 1'b1;
      if (last) state <= FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[r][c] <= in;
  end
endmodule
